// File: rtl/switch_debouncer.sv
// Switch and push-button debouncer feeding an up/down counter.
// Each input: 2-flop synchronizer, then a 4-state debounce FSM.

module debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16,
    parameter bit BOTH_EDGES      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic pulse
);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    // Next state: any reversal during a wait restarts from zero
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE_LOW: begin
                if (din) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = ONE;
                end
            end
            WAIT_HIGH: begin
                if (!din) begin
                    state_d = IDLE_LOW;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE_HIGH;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            IDLE_HIGH: begin
                if (!din) begin
                    state_d = WAIT_LOW;
                    cnt_d   = ONE;
                end
            end
            WAIT_LOW: begin
                if (din) begin
                    state_d = IDLE_HIGH;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE_LOW;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
            end
        endcase
    end

    // Level is high in the two "high" states; pulse on accepted edges
    always_comb begin
        level_d = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
        pulse_d = level_d & ~level_q;
        if (BOTH_EDGES) begin
            pulse_d = level_d ^ level_q;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    input  logic btn_raw,
    output logic up_down_sw,
    output logic step_pulse,
    output logic sw_toggled
);

    logic [1:0] s1, s2;
    logic       btn_level;

    // Two-flop synchronizers; bit 1 = switch, bit 0 = button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
        end else begin
            s1 <= {sw_raw, btn_raw};
            s2 <= s1;
        end
    end

    debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .BOTH_EDGES     (1'b1)
    ) u_sw (
        .clk  (clk),
        .reset(reset),
        .din  (s2[1]),
        .level(up_down_sw),
        .pulse(sw_toggled)
    );

    debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .BOTH_EDGES     (1'b0)
    ) u_btn (
        .clk  (clk),
        .reset(reset),
        .din  (s2[0]),
        .level(btn_level),
        .pulse(step_pulse)
    );

    logic unused_btn_level;
    assign unused_btn_level = btn_level;

endmodule
